axi_wr_slave: RTL and testbench

AXI_WR_SLAVE -- requirements
Module: axi_wr_slave

---
 rtl/axi_wr_slave_if.sv | 41 ++++
 rtl/axi_wr_slave.sv | 134 +++++++++++++
 tb/tb_axi_wr_slave.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_wr_slave_if.sv
// AXI3-style write-channel bundle (AW, W, B) between a write master and axi_wr_slave.
interface axi_wr_slave_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4
);
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [ID_WIDTH-1:0]   awid;
  logic [2:0]            awsize;
  logic [3:0]            awlen;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [31:0]           wdata;
  logic [3:0]            wstrb;
  logic [ID_WIDTH-1:0]   wid;
  logic                  wvalid;
  logic                  wready;
  logic                  wlast;
  logic [1:0]            bresp;
  logic [ID_WIDTH-1:0]   bid;
  logic                  bvalid;
  logic                  bready;

  modport slave (
    input  awaddr, awid, awsize, awlen, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wid, wvalid, wlast,
    output wready,
    output bresp, bid, bvalid,
    input  bready
  );

  modport master (
    output awaddr, awid, awsize, awlen, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wid, wvalid, wlast,
    input  wready,
    input  bresp, bid, bvalid,
    output bready
  );
endinterface

// File: rtl/axi_wr_slave.sv
// Single-outstanding AXI write slave backed by a 32-bit word memory with a debug read port.
module axi_wr_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_WORDS  = 256
) (
  input  logic                         aclk,
  input  logic                         rstn,
  axi_wr_slave_if.slave                bus,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_raddr,
  output logic [31:0]                  mem_rdata
);
  localparam int                  LP_IDXW  = $clog2(MEM_WORDS);
  localparam int                  LP_WAW   = ADDR_WIDTH - 2;
  localparam int                  LP_CMPW  = (LP_WAW > 32) ? LP_WAW : 32;
  localparam logic [LP_CMPW-1:0]  LP_DEPTH = LP_CMPW'(MEM_WORDS);
  localparam logic [LP_WAW-1:0]   LP_ONE   = LP_WAW'(1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t              r_state;
  logic                r_awready;
  logic                r_wready;
  logic                r_bvalid;
  logic [1:0]          r_bresp;
  logic [ID_WIDTH-1:0] r_bid;
  logic [ID_WIDTH-1:0] r_id;
  logic [LP_WAW-1:0]   r_waddr;
  logic [3:0]          r_len;
  logic [3:0]          r_cnt;
  logic                r_incr;
  logic                r_slverr;
  logic                r_decerr;
  logic [31:0]         r_mem [MEM_WORDS];

  logic                w_wbeat;
  logic                w_last;
  logic                w_beat_slv;
  logic                w_beat_dec;
  logic                w_we;
  logic [LP_CMPW-1:0]  w_word;
  logic [LP_IDXW-1:0]  w_widx;

  // Address is kept as a word index: +1 per INCR beat wraps exactly like +4 on the byte address.
  always_comb begin
    w_wbeat    = r_wready && bus.wvalid;
    w_last     = (r_cnt == r_len);
    w_word     = LP_CMPW'(r_waddr);
    w_widx     = w_word[LP_IDXW-1:0];
    w_beat_dec = (w_word >= LP_DEPTH);
    w_beat_slv = r_slverr || (bus.wid != r_id) || (bus.wlast != w_last);
    w_we       = w_wbeat && !w_beat_slv && !w_beat_dec;
  end

  always_ff @(posedge aclk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= '0;
      r_bid     <= '0;
      r_id      <= '0;
      r_waddr   <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_incr    <= 1'b0;
      r_slverr  <= 1'b0;
      r_decerr  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_awready <= 1'b1;
          if (r_awready && bus.awvalid) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_waddr   <= bus.awaddr[ADDR_WIDTH-1:2];
            r_id      <= bus.awid;
            r_len     <= bus.awlen;
            r_cnt     <= '0;
            r_incr    <= (bus.awburst == 2'b01);
            r_slverr  <= (bus.awsize != 3'b010) || bus.awburst[1];
            r_decerr  <= 1'b0;
            r_state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_wbeat) begin
            r_cnt    <= r_cnt + 4'd1;
            r_slverr <= w_beat_slv;
            r_decerr <= r_decerr || w_beat_dec;
            if (r_incr) r_waddr <= r_waddr + LP_ONE;
            if (w_last) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bid    <= r_id;
              r_bresp  <= w_beat_slv ? 2'b10 : ((r_decerr || w_beat_dec) ? 2'b11 : 2'b00);
              r_state  <= S_RESP;
            end
          end
        end
        S_RESP: begin
          if (bus.bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Backing store is deliberately outside the reset domain so completed writes survive rstn.
  always_ff @(posedge aclk) begin
    if (w_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) r_mem[w_widx][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    mem_rdata = '0;
    if (LP_CMPW'(mem_raddr) < LP_DEPTH) mem_rdata = r_mem[mem_raddr];
  end

  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;
  assign bus.bid     = r_bid;

endmodule

// File: tb/tb_axi_wr_slave.sv
// Self-checking bench for axi_wr_slave: directed vector table, hand sequences, randomized bursts.
module tb_axi_wr_slave;
  localparam int AW  = 32;
  localparam int IDW = 4;
  localparam int MW  = 200;
  localparam int LIM = 50;

  logic                  aclk;
  logic                  rstn;
  logic [$clog2(MW)-1:0] mem_raddr;
  logic [31:0]           mem_rdata;

  axi_wr_slave_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IDW)) bus ();

  axi_wr_slave #(.ADDR_WIDTH(AW), .ID_WIDTH(IDW), .MEM_WORDS(MW)) dut (
    .aclk      (aclk),
    .rstn      (rstn),
    .bus       (bus),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errs   = 0;

  logic [31:0] m_mem [MW];
  logic [31:0] bd [16];
  logic [3:0]  bs [16];
  logic [3:0]  bw [16];
  logic        bl [16];

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  len;
    int          badwid;
    int          lastb;
    logic [3:0]  strb;
    logic [31:0] base;
    int          bdelay;
    logic [1:0]  exp;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference: apply the write rules beat by beat to the array, return the expected response code.
  function automatic logic [1:0] model_burst(input logic [31:0] addr, input logic [3:0] id,
                                             input logic [2:0] size, input logic [1:0] burst,
                                             input logic [3:0] len);
    bit          slv;
    bit          dec;
    logic [31:0] a;
    logic [31:0] w;
    slv = (size != 3'd2) || (burst == 2'b10) || (burst == 2'b11);
    dec = 1'b0;
    a   = addr;
    for (int i = 0; i <= int'(len); i++) begin
      if (bw[i] != id) slv = 1'b1;
      if (bl[i] != (i == int'(len))) slv = 1'b1;
      w = a / 4;
      if (w >= MW) dec = 1'b1;
      else if (!slv) begin
        for (int b = 0; b < 4; b++)
          if (bs[i][b]) m_mem[w][8*b +: 8] = bd[i][8*b +: 8];
      end
      if (burst == 2'b01) a = a + 32'd4;
    end
    return slv ? 2'b10 : (dec ? 2'b11 : 2'b00);
  endfunction

  task automatic fill(input logic [31:0] base, input logic [3:0] strb, input logic [3:0] id,
                      input int badwid, input int lastb);
    for (int i = 0; i < 16; i++) begin
      bd[i] = base + 32'(i);
      bs[i] = strb;
      bw[i] = (i == badwid) ? (id ^ 4'h1) : id;
      bl[i] = (i == lastb);
    end
  endtask

  task automatic sweep_mem(input string name);
    for (int i = 0; i < 256; i++) begin
      mem_raddr = 8'(i);
      #1;
      chk(name, mem_rdata, (i < MW) ? m_mem[i] : 32'd0);
      if (i % 4 == 3) @(negedge aclk);
    end
  endtask

  // Called at a negedge with the slave idle.
  task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input logic [2:0] size,
                           input logic [1:0] burst, input logic [3:0] len, input int gapmax,
                           input int bdelay, output logic [1:0] resp, output logic [3:0] rid);
    int g;
    int gaps;
    bus.awaddr  = addr;
    bus.awid    = id;
    bus.awsize  = size;
    bus.awburst = burst;
    bus.awlen   = len;
    bus.awvalid = 1'b1;
    g = 0;
    while (!bus.awready && g < LIM) begin @(negedge aclk); g++; end
    chk("aw_timeout", 32'(g >= LIM), 32'd0);
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("awready_data", 32'(bus.awready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (gaps) begin bus.wvalid = 1'b0; @(negedge aclk); end
      bus.wvalid = 1'b1;
      bus.wdata  = bd[i];
      bus.wstrb  = bs[i];
      bus.wid    = bw[i];
      bus.wlast  = bl[i];
      g = 0;
      while (!bus.wready && g < LIM) begin @(negedge aclk); g++; end
      chk("w_timeout", 32'(g >= LIM), 32'd0);
      @(negedge aclk);
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    chk("b_latency", 32'(bus.bvalid), 32'd1);
    chk("wready_resp", 32'(bus.wready), 32'd0);
    resp = bus.bresp;
    rid  = bus.bid;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge aclk);
      chk("bvalid_hold", 32'(bus.bvalid), 32'd1);
      chk("bresp_hold", 32'(bus.bresp), 32'(resp));
      chk("bid_hold", 32'(bus.bid), 32'(rid));
      chk("awready_resp", 32'(bus.awready), 32'd0);
    end
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;
    chk("bvalid_clear", 32'(bus.bvalid), 32'd0);
    chk("awready_return", 32'(bus.awready), 32'd1);
  endtask

  initial begin
    logic [1:0]  resp;
    logic [1:0]  exp;
    logic [3:0]  rid;
    logic [3:0]  len;
    logic [31:0] addr;
    logic [31:0] old;
    logic [3:0]  id;
    logic [2:0]  size;
    logic [1:0]  burst;

    tbl = '{
      '{32'h10,             4'd5,  3'd2, 2'b01, 4'd3, -1,  3, 4'hF, 32'hA0,       0, 2'b00},
      '{32'h80,             4'd2,  3'd2, 2'b10, 4'd0, -1,  0, 4'hF, 32'hDEAD0000, 0, 2'b10},
      '{32'h80,             4'd3,  3'd0, 2'b01, 4'd0, -1,  0, 4'hF, 32'hBEEF0000, 0, 2'b10},
      '{32'((MW-1)*4),      4'd6,  3'd2, 2'b01, 4'd1, -1,  1, 4'hF, 32'h5A5A0000, 0, 2'b11},
      '{32'h40,             4'd7,  3'd2, 2'b01, 4'd3,  2,  3, 4'hF, 32'h12300000, 0, 2'b10},
      '{32'h60,             4'd8,  3'd2, 2'b01, 4'd3, -1,  1, 4'hF, 32'h77000000, 5, 2'b10},
      '{32'h70,             4'd9,  3'd2, 2'b01, 4'd1, -1, -1, 4'hF, 32'h99000000, 0, 2'b10},
      '{32'h80,             4'd10, 3'd2, 2'b11, 4'd1, -1,  1, 4'hF, 32'hAB000000, 0, 2'b10},
      '{32'h23,             4'd11, 3'd2, 2'b01, 4'd2, -1,  2, 4'h5, 32'hC0DE0000, 0, 2'b00},
      '{32'(MW*4),          4'd12, 3'd2, 2'b00, 4'd1, -1,  1, 4'hF, 32'hE0000000, 0, 2'b11},
      '{32'((MW-1)*4),      4'd13, 3'd1, 2'b01, 4'd1, -1,  1, 4'hF, 32'hF1000000, 0, 2'b10},
      '{32'hFFFFFFFC,       4'd14, 3'd2, 2'b01, 4'd1, -1,  1, 4'h3, 32'h3C3C0000, 0, 2'b11},
      '{32'h90,             4'd15, 3'd2, 2'b00, 4'd3, -1,  3, 4'hF, 32'h4B000000, 0, 2'b00}
    };

    rstn = 1'b0;
    mem_raddr = '0;
    bus.awaddr = '0; bus.awid = '0; bus.awsize = '0; bus.awlen = '0; bus.awburst = '0;
    bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wid = '0; bus.wvalid = 1'b0;
    bus.wlast = 1'b0; bus.bready = 1'b0;

    // Reset values, then awready after the first edge with rstn high.
    @(negedge aclk);
    chk("rst_awready", 32'(bus.awready), 32'd0);
    chk("rst_wready", 32'(bus.wready), 32'd0);
    chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("rst_bresp", 32'(bus.bresp), 32'd0);
    chk("rst_bid", 32'(bus.bid), 32'd0);
    rstn = 1'b1;
    @(negedge aclk);
    chk("post_rst_awready", 32'(bus.awready), 32'd1);
    chk("idle_wready", 32'(bus.wready), 32'd0);

    // Preload every word so the model and memory start identical.
    for (int w = 0; w < MW; w += 16) begin
      len = 4'((MW - 1 - w) < 15 ? (MW - 1 - w) : 15);
      for (int i = 0; i < 16; i++) begin
        bd[i] = $urandom; bs[i] = 4'hF; bw[i] = 4'd0; bl[i] = (i == int'(len));
      end
      exp = model_burst(32'(w * 4), 4'd0, 3'd2, 2'b01, len);
      run_burst(32'(w * 4), 4'd0, 3'd2, 2'b01, len, 0, 0, resp, rid);
      chk("preload_bresp", 32'(resp), 32'(exp));
    end
    sweep_mem("preload_mem");

    for (int v = 0; v < 13; v++) begin
      fill(tbl[v].base, tbl[v].strb, tbl[v].id, tbl[v].badwid, tbl[v].lastb);
      exp = model_burst(tbl[v].addr, tbl[v].id, tbl[v].size, tbl[v].burst, tbl[v].len);
      run_burst(tbl[v].addr, tbl[v].id, tbl[v].size, tbl[v].burst, tbl[v].len, 0,
                tbl[v].bdelay, resp, rid);
      chk($sformatf("vec%0d_bresp", v), 32'(resp), 32'(tbl[v].exp));
      chk($sformatf("vec%0d_bid", v), 32'(rid), 32'(tbl[v].id));
      sweep_mem($sformatf("vec%0d_mem", v));
    end

    // FIXED burst merging two beats into one word with different strobes.
    fill(32'h0, 4'hF, 4'd1, -1, 1);
    bd[0] = 32'h11223344; bs[0] = 4'hF;
    bd[1] = 32'h55667788; bs[1] = 4'h3;
    exp = model_burst(32'h8, 4'd1, 3'd2, 2'b00, 4'd1);
    run_burst(32'h8, 4'd1, 3'd2, 2'b00, 4'd1, 0, 0, resp, rid);
    chk("fixed_bresp", 32'(resp), 32'd0);
    mem_raddr = 8'd2;
    #1;
    chk("fixed_mem2", mem_rdata, 32'h11227788);
    @(negedge aclk);

    // W presented before AW is ignored; a write lands on the debug port only after its edge.
    old = m_mem[3];
    mem_raddr = 8'd3;
    bus.wvalid = 1'b1; bus.wdata = 32'hCAFEF00D; bus.wstrb = 4'hF; bus.wid = 4'd4; bus.wlast = 1'b1;
    repeat (3) begin
      @(negedge aclk);
      chk("w_before_aw", 32'(bus.wready), 32'd0);
    end
    chk("w_before_aw_mem", mem_rdata, old);
    bus.awaddr = 32'hC; bus.awid = 4'd4; bus.awsize = 3'd2; bus.awburst = 2'b00; bus.awlen = 4'd0;
    bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    chk("vis_wready", 32'(bus.wready), 32'd1);
    chk("vis_before_edge", mem_rdata, old);
    @(negedge aclk);
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
    chk("vis_after_edge", mem_rdata, 32'hCAFEF00D);
    m_mem[3] = 32'hCAFEF00D;
    chk("vis_bresp", 32'(bus.bresp), 32'd0);
    bus.bready = 1'b1;
    @(negedge aclk);
    bus.bready = 1'b0;

    // Reset two beats into a four-beat burst: no response, first beats persist.
    bus.awaddr = 32'h40; bus.awid = 4'd3; bus.awsize = 3'd2; bus.awburst = 2'b01; bus.awlen = 4'd3;
    bus.awvalid = 1'b1;
    @(negedge aclk);
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.wvalid = 1'b1; bus.wdata = 32'h0BAD0000 + 32'(i); bus.wstrb = 4'hF;
      bus.wid = 4'd3; bus.wlast = 1'b0;
      @(negedge aclk);
      m_mem[16 + i] = 32'h0BAD0000 + 32'(i);
    end
    bus.wvalid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("midrst_awready", 32'(bus.awready), 32'd0);
    chk("midrst_wready", 32'(bus.wready), 32'd0);
    chk("midrst_bvalid", 32'(bus.bvalid), 32'd0);
    chk("midrst_bresp", 32'(bus.bresp), 32'd0);
    chk("midrst_bid", 32'(bus.bid), 32'd0);
    @(negedge aclk);
    rstn = 1'b1;
    @(negedge aclk);
    chk("midrst_release_awready", 32'(bus.awready), 32'd1);
    chk("midrst_release_bvalid", 32'(bus.bvalid), 32'd0);
    sweep_mem("midrst_mem");

    // Randomized bursts against the reference model.
    for (int t = 0; t < 30; t++) begin
      id    = 4'($urandom);
      len   = 4'($urandom);
      addr  = 32'($urandom_range(MW + 4, 0) * 4) | 32'($urandom_range(3, 0));
      size  = ($urandom_range(9, 0) == 0) ? 3'($urandom) : 3'd2;
      burst = ($urandom_range(9, 0) == 0) ? 2'($urandom) : 2'($urandom_range(1, 0));
      for (int i = 0; i < 16; i++) begin
        bd[i] = $urandom;
        bs[i] = 4'($urandom);
        bw[i] = ($urandom_range(19, 0) == 0) ? 4'($urandom) : id;
        bl[i] = (i == int'(len));
      end
      if ($urandom_range(9, 0) == 0) begin
        int j;
        j = int'($urandom_range(int'(len), 0));
        bl[j] = !bl[j];
      end
      exp = model_burst(addr, id, size, burst, len);
      run_burst(addr, id, size, burst, len, 2, int'($urandom_range(3, 0)), resp, rid);
      chk("rand_bresp", 32'(resp), 32'(exp));
      chk("rand_bid", 32'(rid), 32'(id));
      sweep_mem("rand_mem");
    end

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
